burst_rr_arbiter: RTL and testbench
===================================

// Module: burst_rr_arbiter
// PURPOSE
//  Round-robin arbiter granting one of NUM_REQ requesters (e.g. per-bank command queues) exclusive use of a shared
//  downstream channel for a multi-beat burst. Lowest-index-first selection among requesters above the last winner;
//  wraps to the full vector when none are above. Sits between bank queues and the DDR command/data issue stage.
// PARAMETERS
//  NUM_REQ  8                  number of requesters (>=2, power of 2 not required)
//  BURST_W  3                  width of burst length field; burst = req_len+1 beats (1..2^BURST_W)
//  IDX_W    $clog2(NUM_REQ)    grant index width (derived, do not override)
// PORTS
//  clk        in   1                  clock, all logic on rising edge
//  rst        in   1                  synchronous reset, active-high
//  req_valid  in   NUM_REQ            requester i has a beat ready; must stay high until burst completes
//  req_len    in   NUM_REQ*BURST_W    per-requester beats-minus-one, sampled only at grant
//  req_ready  out  NUM_REQ            beat of requester i accepted this cycle (one-hot or zero)
//  gnt_valid  out  1                  beat presented downstream
//  gnt_idx    out  IDX_W              current owner index
//  gnt_last   out  1                  presented beat is final beat of burst
//  gnt_ready  in   1                  downstream accepts beat
//  busy       out  1                  arbiter in GRANT state
// BEHAVIOUR
//  - Reset: state=IDLE, ptr=NUM_REQ-1, beat_cnt=0, owner=0; all outputs 0.
//  - Pick: mask = bits strictly above ptr; win = LSB-first(req_valid & mask) if nonzero, else LSB-first(req_valid).
//  - IDLE: if |req_valid -> owner<=win, beat_cnt<=req_len[win], state<=GRANT. No outputs asserted in IDLE;
//    grant latency 1 cycle from req_valid to gnt_valid.
//  - GRANT: gnt_valid = req_valid[owner]; gnt_idx=owner; gnt_last=(beat_cnt==0);
//    req_ready[owner] = gnt_valid & gnt_ready, other bits 0 (combinational pass-through).
//  - Beat handshake (gnt_valid & gnt_ready): if beat_cnt!=0 -> beat_cnt-1, else last beat:
//    ptr<=owner; recompute pick with mask relative to owner using current req_valid (owner's bit included, so a
//    lone requester re-wins); if any req -> owner<=win, beat_cnt<=req_len[win], stay GRANT (zero-bubble);
//    else -> IDLE.
//  - req_valid[owner] low mid-burst: gnt_valid=0, beat_cnt/owner hold (stall); ownership is never revoked.
//  - gnt_ready low: everything holds; no beat counted.
//  - Requests arriving mid-burst do not pre-empt; considered only at burst end.
//  - ptr=NUM_REQ-1 gives empty mask -> pure LSB-first pick (requester 0 highest after reset).
//  - rst asserted mid-burst: abandon burst, return to reset values next edge; no gnt_last emitted.
//  - busy = (state==GRANT). All counters unsigned, BURST_W wide, no wrap (decrement only while !=0).
// STRUCTURE
//  - Shared package ddr_arb_pkg: typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t; localparam default widths.
//  - One sub-module rr_pick (NUM_REQ): inputs req vector + ptr, output win index + any flag; internally masked and
//    unmasked LSB-first encoders with masked-first select. Instantiated once; FSM, counter, ptr in top.
//  - Registered: state, owner, ptr, beat_cnt. Outputs in GRANT are combinational from registers + req_valid/gnt_ready.
// TESTING
//  1) After reset, req_valid=8'b1010_0100, all len=0, gnt_ready=1 -> grants 2,5,7, then 2 again; one beat each, gnt_last=1.
//  2) req_valid=8'h01 constant, len[0]=3 -> 4 beats idx0, gnt_last only on 4th, then re-grant idx0 with no bubble cycle.
//  3) Burst idx3 len=2, gnt_ready low 2 cycles mid-burst -> beat_cnt holds, exactly 3 req_ready[3] pulses total.
//  4) req_valid[owner] drops 1 cycle mid-burst while req 6 valid -> gnt_valid=0 that cycle, owner stays, no switch.
//  5) rst mid-burst (beat 2 of 4) -> next cycle all outputs 0, busy=0; subsequent pick starts from req 0.
//  6) Random req/len/ready, 10k cycles -> scoreboard: req_ready one-hot-or-zero, beats=len+1 per grant, no starvation >NUM_REQ bursts.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// Shared types and default widths for the DDR burst arbiter.
package ddr_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int DEF_NUM_REQ = 8;
    localparam int DEF_BURST_W = 3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: lowest requester strictly above ptr, else lowest overall.
module rr_pick
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   win,
    output logic               any
);

    logic             m_any, u_any;
    logic [IDX_W-1:0] m_idx, u_idx;

    // Masked and unmasked LSB-first encoders; scanning downward leaves the lowest hit.
    always_comb begin
        m_any = 1'b0;
        m_idx = '0;
        u_any = 1'b0;
        u_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                u_any = 1'b1;
                u_idx = IDX_W'(i);
                if (IDX_W'(i) > ptr) begin
                    m_any = 1'b1;
                    m_idx = IDX_W'(i);
                end
            end
        end
    end

    assign win = m_any ? m_idx : u_idx;
    assign any = u_any;

endmodule

// File: rtl/burst_rr_arbiter.sv
// Burst round-robin arbiter: grants one requester the downstream channel for req_len+1 beats.
module burst_rr_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int BURST_W = DEF_BURST_W,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*BURST_W-1:0] req_len,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       gnt_valid,
    output logic [IDX_W-1:0]           gnt_idx,
    output logic                       gnt_last,
    input  logic                       gnt_ready,
    output logic                       busy
);

    arb_state_t                       state_q, state_d;
    logic [IDX_W-1:0]                 owner_q, owner_d;
    logic [IDX_W-1:0]                 ptr_q, ptr_d;
    logic [BURST_W-1:0]               cnt_q, cnt_d;
    logic [NUM_REQ-1:0][BURST_W-1:0]  len_arr;
    logic [IDX_W-1:0]                 pick_ptr, win;
    logic                             any_req, hs;

    assign len_arr = req_len;

    // At a burst boundary the rotation is relative to the finishing owner, so the
    // owner's own bit stays in the unmasked fallback and a lone requester re-wins.
    assign pick_ptr = (state_q == ARB_GRANT) ? owner_q : ptr_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (pick_ptr),
        .win     (win),
        .any     (any_req)
    );

    // State, owner, pointer and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and grant outputs; a dropped owner request only stalls, never revokes.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        busy      = (state_q == ARB_GRANT);
        gnt_valid = busy & req_valid[owner_q];
        gnt_idx   = busy ? owner_q : '0;
        gnt_last  = busy & (cnt_q == '0);
        hs        = gnt_valid & gnt_ready;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    owner_d = win;
                    cnt_d   = len_arr[win];
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (hs) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        ptr_d = owner_q;
                        if (any_req) begin
                            owner_d = win;
                            cnt_d   = len_arr[win];
                        end else begin
                            state_d = ARB_IDLE;
                        end
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Per-requester accept strobe, only the owner can see a beat taken.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
        assign req_ready[i] = hs & (owner_q == IDX_W'(i));
    end

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Self-checking bench for burst_rr_arbiter: directed scenarios plus randomized scoreboard run.
module tb_burst_rr_arbiter;

    localparam int N  = 8;
    localparam int BW = 3;
    localparam int IW = 3;

    typedef struct packed {
        logic          gv;
        logic [IW-1:0] idx;
        logic          last;
        logic [N-1:0]  rr;
        logic          busy;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*BW-1:0] req_len;
    logic [N-1:0]    req_ready;
    logic            gnt_valid;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_last;
    logic            gnt_ready;
    logic            busy;

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    int   burstq[$];

    always #5 clk = ~clk;

    burst_rr_arbiter #(.NUM_REQ(N), .BURST_W(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_ready (req_ready),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_last  (gnt_last),
        .gnt_ready (gnt_ready),
        .busy      (busy)
    );

    function automatic exp_t mk(logic gv, int idx, logic last, logic [N-1:0] rr, logic b);
        exp_t e;
        e.gv = gv; e.idx = IW'(idx); e.last = last; e.rr = rr; e.busy = b;
        return e;
    endfunction

    function automatic exp_t obs();
        exp_t o;
        o.gv = gnt_valid; o.idx = gnt_idx; o.last = gnt_last; o.rr = req_ready; o.busy = busy;
        return o;
    endfunction

    // Reference pick: first valid requester scanning upward from p+1, wrapping through p itself.
    function automatic int rr_scan(int p, logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (p + k) % N;
            if (v[j]) return j;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_len(int i, int v);
        req_len[i*BW +: BW] = BW'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_len = '0; gnt_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e, o;
        rst = 1'b1; req_valid = 8'hFF; req_len = '1; gnt_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expq.push_back(mk(0, 0, 0, 8'h00, 0));
            #1;
            e = expq.pop_front(); o = obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset cyc%0d: got %h want %h", k, o, e); end
        end
        rst = 1'b0; req_valid = '0;
        tick();
        expq.push_back(mk(0, 0, 0, 8'h00, 0));
        #1;
        e = expq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_idle: got %h want %h", o, e); end
    endtask

    task automatic test_rr_order();
        exp_t e, o;
        int   seq[4];
        seq = '{2, 5, 7, 2};
        do_reset();
        req_valid = 8'b1010_0100; gnt_ready = 1'b1;
        expq.push_back(mk(0, 0, 0, 8'h00, 0));
        #1;
        e = expq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL rr_latency: got %h want %h", o, e); end
        for (int k = 0; k < 4; k++) begin
            tick();
            expq.push_back(mk(1, seq[k], 1, 8'(1 << seq[k]), 1));
            #1;
            e = expq.pop_front(); o = obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL rr_order beat%0d: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_burst_rewin();
        exp_t e, o;
        do_reset();
        req_valid = 8'h01; set_len(0, 3); gnt_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) expq.push_back(mk(0, 0, 0, 8'h00, 0));
            else        expq.push_back(mk(1, 0, k == 4, 8'h01, 1));
            #1;
            e = expq.pop_front(); o = obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL burst_rewin cyc%0d: got %h want %h", k, o, e); end
            tick();
        end
    endtask

    task automatic test_ready_stall();
        exp_t e, o;
        logic rdy[5];
        int   pulses;
        rdy = '{1, 0, 0, 1, 1};
        pulses = 0;
        do_reset();
        req_valid = 8'h08; set_len(3, 2);
        tick();
        for (int k = 0; k < 5; k++) begin
            gnt_ready = rdy[k];
            expq.push_back(mk(1, 3, k == 4, rdy[k] ? 8'h08 : 8'h00, 1));
            #1;
            e = expq.pop_front(); o = obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL ready_stall cyc%0d: got %h want %h", k, o, e); end
            pulses += int'(req_ready[3]);
            tick();
        end
        checks++;
        if (pulses !== 3) begin errors++; $display("FAIL ready_stall_pulses: got %0d want 3", pulses); end
    endtask

    task automatic test_owner_drop();
        exp_t e, o;
        logic [N-1:0] rv[5];
        rv = '{8'h42, 8'h40, 8'h42, 8'h42, 8'h42};
        do_reset();
        req_valid = 8'h42; set_len(1, 2); set_len(6, 0); gnt_ready = 1'b1;
        tick();
        expq.push_back(mk(1, 1, 0, 8'h02, 1));
        expq.push_back(mk(0, 1, 0, 8'h00, 1));
        expq.push_back(mk(1, 1, 0, 8'h02, 1));
        expq.push_back(mk(1, 1, 1, 8'h02, 1));
        expq.push_back(mk(1, 6, 1, 8'h40, 1));
        for (int k = 0; k < 5; k++) begin
            req_valid = rv[k];
            #1;
            e = expq.pop_front(); o = obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL owner_drop cyc%0d: got %h want %h", k, o, e); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        do_reset();
        req_valid = 8'h08; set_len(3, 0); gnt_ready = 1'b1;
        tick();
        set_len(3, 3);
        expq.push_back(mk(1, 3, 1, 8'h08, 1));
        expq.push_back(mk(1, 3, 0, 8'h08, 1));
        expq.push_back(mk(1, 3, 0, 8'h08, 1));
        for (int k = 0; k < 3; k++) begin
            if (k == 2) rst = 1'b1;
            #1;
            e = expq.pop_front(); o = obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset_mid beat%0d: got %h want %h", k, o, e); end
            tick();
        end
        expq.push_back(mk(0, 0, 0, 8'h00, 0));
        #1;
        e = expq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_mid_clear: got %h want %h", o, e); end
        rst = 1'b0; req_valid = 8'h11; set_len(0, 0);
        tick();
        expq.push_back(mk(1, 0, 1, 8'h01, 1));
        #1;
        e = expq.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_mid_ptr: got %h want %h", o, e); end
    endtask

    task automatic test_random();
        exp_t         e, o;
        logic         m_st;
        int           m_own, m_ptr, m_cnt, w, beats, maxwait, want;
        int           waitc[N];
        logic [N-1:0] rv, rv_prev;
        logic         dec_prev;
        do_reset();
        m_st = 1'b0; m_own = 0; m_ptr = N - 1; m_cnt = 0;
        beats = 0; maxwait = 0; dec_prev = 1'b0; rv_prev = '0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        burstq.delete();
        for (int c = 0; c < 10000; c++) begin
            rv = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom | $urandom) & N'($urandom);
            if (m_st && $urandom_range(0, 7) != 0) rv[m_own] = 1'b1;
            req_valid = rv;
            for (int i = 0; i < N; i++) set_len(i, $urandom_range(0, 7));
            gnt_ready = ($urandom_range(0, 3) != 0);
            e.gv   = m_st && rv[m_own];
            e.idx  = m_st ? IW'(m_own) : '0;
            e.last = m_st && (m_cnt == 0);
            e.rr   = (e.gv && gnt_ready) ? N'(1 << m_own) : '0;
            e.busy = m_st;
            expq.push_back(e);
            #1;
            e = expq.pop_front(); o = obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL random cyc%0d: got %h want %h", c, o, e); end
            checks++;
            if (!$onehot0(req_ready)) begin errors++; $display("FAIL random_onehot cyc%0d: got %b want one-hot-or-zero", c, req_ready); end
            if (req_ready != '0) beats++;
            if (req_ready != '0 && gnt_last) begin
                want = (burstq.size() != 0) ? burstq.pop_front() : -1;
                checks++;
                if (beats !== want) begin errors++; $display("FAIL random_beats cyc%0d: got %0d want %0d", c, beats, want); end
                beats = 0;
            end
            if (dec_prev) begin
                for (int i = 0; i < N; i++) begin
                    if (i == int'(gnt_idx) || !rv_prev[i]) waitc[i] = 0;
                    else waitc[i]++;
                    if (waitc[i] > maxwait) maxwait = waitc[i];
                end
            end
            dec_prev = (!busy && (req_valid != '0)) || (gnt_valid && gnt_ready && gnt_last);
            rv_prev  = req_valid;
            if (!m_st) begin
                if (rv != '0) begin
                    w = rr_scan(m_ptr, rv); m_own = w; m_cnt = int'(req_len[w*BW +: BW]);
                    m_st = 1'b1; burstq.push_back(m_cnt + 1);
                end
            end else if (m_st && rv[m_own] && gnt_ready) begin
                if (m_cnt != 0) m_cnt--;
                else begin
                    m_ptr = m_own;
                    if (rv != '0) begin
                        w = rr_scan(m_own, rv); m_own = w; m_cnt = int'(req_len[w*BW +: BW]);
                        burstq.push_back(m_cnt + 1);
                    end else m_st = 1'b0;
                end
            end
            tick();
        end
        checks++;
        if (maxwait >= N) begin errors++; $display("FAIL random_starvation: got %0d lost decisions want < %0d", maxwait, N); end
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_burst_rewin();
        test_ready_stall();
        test_owner_drop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
